// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold handling
// and a saturating count of inserted load-use bubbles.
module id_ex_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [7:0]       id_ctrl,
  input  logic [31:0]      id_pc,
  input  logic [31:0]      id_rs1_data,
  input  logic [31:0]      id_rs2_data,
  input  logic [31:0]      id_imm,
  input  logic [14:0]      id_regs,
  input  logic [3:0]       id_funct,
  input  logic             flush,
  input  logic             ex_hold,
  output logic             stall,
  output logic             ex_valid,
  output logic [7:0]       ex_ctrl,
  output logic [31:0]      ex_pc,
  output logic [31:0]      ex_rs1_data,
  output logic [31:0]      ex_rs2_data,
  output logic [31:0]      ex_imm,
  output logic [14:0]      ex_regs,
  output logic [3:0]       ex_funct,
  output logic [CNT_W-1:0] bubble_count
);

  logic             valid_q, valid_d;
  logic [7:0]       ctrl_q, ctrl_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      rs1_q, rs1_d;
  logic [31:0]      rs2_q, rs2_d;
  logic [31:0]      imm_q, imm_d;
  logic [14:0]      regs_q, regs_d;
  logic [3:0]       funct_q, funct_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [4:0] ex_rd_s;
  logic       load_use_s;

  // A load in EX (MemRead) writing a nonzero rd that ID reads forces one bubble.
  assign ex_rd_s    = regs_q[4:0];
  assign load_use_s = id_valid & valid_q & ctrl_q[5] & (ex_rd_s != 5'd0) &
                      ((ex_rd_s == id_regs[14:10]) | (ex_rd_s == id_regs[9:5]));
  assign stall      = ~flush & (load_use_s | ex_hold);

  // Next-state selection: flush > hold > load-use bubble > capture.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    pc_d    = pc_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    imm_d   = imm_q;
    regs_d  = regs_q;
    funct_d = funct_q;
    cnt_d   = cnt_q;
    if (flush || (!ex_hold && load_use_s)) begin
      valid_d = 1'b0;
      ctrl_d  = 8'd0;
      pc_d    = 32'd0;
      rs1_d   = 32'd0;
      rs2_d   = 32'd0;
      imm_d   = 32'd0;
      regs_d  = 15'd0;
      funct_d = 4'd0;
      if (!flush && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else if (ex_hold) begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
    end else begin
      valid_d = id_valid;
      ctrl_d  = id_valid ? id_ctrl : 8'd0;
      pc_d    = id_pc;
      rs1_d   = id_rs1_data;
      rs2_d   = id_rs2_data;
      imm_d   = id_imm;
      regs_d  = id_regs;
      funct_d = id_funct;
    end
  end

  // Pipeline register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= 8'd0;
      pc_q    <= 32'd0;
      rs1_q   <= 32'd0;
      rs2_q   <= 32'd0;
      imm_q   <= 32'd0;
      regs_q  <= 15'd0;
      funct_q <= 4'd0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      pc_q    <= pc_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
      regs_q  <= regs_d;
      funct_q <= funct_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_ctrl      = ctrl_q;
  assign ex_pc        = pc_q;
  assign ex_rs1_data  = rs1_q;
  assign ex_rs2_data  = rs2_q;
  assign ex_imm       = imm_q;
  assign ex_regs      = regs_q;
  assign ex_funct     = funct_q;
  assign bubble_count = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios then random traffic, checked against
// a reference model; a second instance with CNT_W=2 exercises counter saturation.
module tb_id_ex_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, id_valid, flush, ex_hold;
  logic [7:0]  id_ctrl;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [14:0] id_regs;
  logic [3:0]  id_funct;

  logic        stall, ex_valid;
  logic [7:0]  ex_ctrl;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [14:0] ex_regs;
  logic [3:0]  ex_funct;
  logic [15:0] bubble_count;

  logic        stall2, ex_valid2;
  logic [7:0]  ex_ctrl2;
  logic [31:0] ex_pc2, ex_rs1_data2, ex_rs2_data2, ex_imm2;
  logic [14:0] ex_regs2;
  logic [3:0]  ex_funct2;
  logic [1:0]  bubble_count2;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_regs(id_regs), .id_funct(id_funct), .flush(flush), .ex_hold(ex_hold),
    .stall(stall), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_regs(ex_regs), .ex_funct(ex_funct), .bubble_count(bubble_count)
  );

  id_ex_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_regs(id_regs), .id_funct(id_funct), .flush(flush), .ex_hold(ex_hold),
    .stall(stall2), .ex_valid(ex_valid2), .ex_ctrl(ex_ctrl2), .ex_pc(ex_pc2),
    .ex_rs1_data(ex_rs1_data2), .ex_rs2_data(ex_rs2_data2), .ex_imm(ex_imm2),
    .ex_regs(ex_regs2), .ex_funct(ex_funct2), .bubble_count(bubble_count2)
  );

  int checks = 0;
  int errors = 0;

  // Reference model of what EX should hold.
  logic        m_valid;
  logic [7:0]  m_ctrl;
  logic [31:0] m_pc, m_rs1, m_rs2, m_imm;
  logic [14:0] m_regs;
  logic [3:0]  m_funct;
  int          m_cnt, m_cnt2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_bubble();
    m_valid = 1'b0; m_ctrl = 8'd0; m_pc = 32'd0; m_rs1 = 32'd0; m_rs2 = 32'd0;
    m_imm = 32'd0; m_regs = 15'd0; m_funct = 4'd0;
  endtask

  task automatic set_id(input logic v, input logic [7:0] c, input logic [31:0] pc,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    id_valid    = v;
    id_ctrl     = c;
    id_pc       = pc;
    id_rs1_data = $urandom;
    id_rs2_data = $urandom;
    id_imm      = $urandom;
    id_regs     = {rs1, rs2, rd};
    id_funct    = 4'($urandom_range(0, 15));
  endtask

  // One clock: check stall before the edge, advance the model, check outputs after.
  task automatic step();
    logic hazard, exp_stall;
    #1;
    hazard = id_valid && m_valid && m_ctrl[5] && (m_regs[4:0] != 5'd0) &&
             (m_regs[4:0] == id_regs[14:10] || m_regs[4:0] == id_regs[9:5]);
    exp_stall = !flush && (hazard || ex_hold);
    chk("stall", {63'd0, stall}, {63'd0, exp_stall});
    chk("stall_w2", {63'd0, stall2}, {63'd0, exp_stall});
    @(posedge clk);
    if (rst) begin
      model_bubble();
      m_cnt = 0; m_cnt2 = 0;
    end else if (flush) begin
      model_bubble();
    end else if (ex_hold) begin
      m_valid = m_valid;
    end else if (hazard) begin
      model_bubble();
      m_cnt  = (m_cnt  < 65535) ? m_cnt  + 1 : m_cnt;
      m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : m_cnt2;
    end else begin
      m_valid = id_valid;
      m_ctrl  = id_valid ? id_ctrl : 8'd0;
      m_pc = id_pc; m_rs1 = id_rs1_data; m_rs2 = id_rs2_data;
      m_imm = id_imm; m_regs = id_regs; m_funct = id_funct;
    end
    #1;
    chk("ex_valid", {63'd0, ex_valid}, {63'd0, m_valid});
    chk("ex_ctrl", {56'd0, ex_ctrl}, {56'd0, m_ctrl});
    chk("ex_pc", {32'd0, ex_pc}, {32'd0, m_pc});
    chk("ex_rs1_data", {32'd0, ex_rs1_data}, {32'd0, m_rs1});
    chk("ex_rs2_data", {32'd0, ex_rs2_data}, {32'd0, m_rs2});
    chk("ex_imm", {32'd0, ex_imm}, {32'd0, m_imm});
    chk("ex_regs", {49'd0, ex_regs}, {49'd0, m_regs});
    chk("ex_funct", {60'd0, ex_funct}, {60'd0, m_funct});
    chk("bubble_count", {48'd0, bubble_count}, 64'(m_cnt));
    chk("bubble_count_w2", {62'd0, bubble_count2}, 64'(m_cnt2));
    chk("w2_pipe", {ex_valid2, ex_ctrl2, ex_pc2, ex_regs2, ex_funct2, 4'd0},
                   {ex_valid, ex_ctrl, ex_pc, ex_regs, ex_funct, 4'd0});
    chk("no_store_when_invalid", {63'd0, (!ex_valid && (ex_ctrl[4] || ex_ctrl[3]))}, 64'd0);
  endtask

  initial begin
    logic [31:0] held_pc;
    model_bubble();
    m_cnt = 0; m_cnt2 = 0;
    rst = 1'b1; flush = 1'b0; ex_hold = 1'b0;
    set_id(1'b0, 8'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    step();
    chk("reset_valid", {63'd0, ex_valid}, 64'd0);
    rst = 1'b0;
    step();
    chk("after_reset_stall", {63'd0, stall}, 64'd0);

    // Plain capture.
    set_id(1'b1, 8'h88, 32'h100, 5'd1, 5'd2, 5'd3);
    step();
    chk("cap_ctrl", {56'd0, ex_ctrl}, 64'h88);
    chk("cap_pc", {32'd0, ex_pc}, 64'h100);

    // Load-use: load to x5, then consumer of x5 costs one bubble.
    set_id(1'b1, 8'h2D, 32'h104, 5'd1, 5'd2, 5'd5);
    step();
    set_id(1'b1, 8'h88, 32'h108, 5'd5, 5'd6, 5'd7);
    #1 chk("lu_stall", {63'd0, stall}, 64'd1);
    step();
    chk("lu_bubble_valid", {63'd0, ex_valid}, 64'd0);
    chk("lu_count", {48'd0, bubble_count}, 64'd1);
    step();
    chk("lu_resume_pc", {32'd0, ex_pc}, 64'h108);

    // Load to x0 never stalls.
    set_id(1'b1, 8'h2D, 32'h10C, 5'd1, 5'd2, 5'd0);
    step();
    set_id(1'b1, 8'h88, 32'h110, 5'd0, 5'd0, 5'd4);
    step();
    chk("x0_pc", {32'd0, ex_pc}, 64'h110);
    chk("x0_count", {48'd0, bubble_count}, 64'd1);

    // Flush overrides load-use and hold.
    set_id(1'b1, 8'h2D, 32'h114, 5'd1, 5'd2, 5'd9);
    step();
    set_id(1'b1, 8'h88, 32'h118, 5'd9, 5'd9, 5'd1);
    flush = 1'b1; ex_hold = 1'b1;
    step();
    chk("flush_count", {48'd0, bubble_count}, 64'd1);
    flush = 1'b0; ex_hold = 1'b0;

    // Hold for three cycles with changing ID inputs.
    set_id(1'b1, 8'h0F, 32'h200, 5'd3, 5'd4, 5'd8);
    step();
    held_pc = ex_pc;
    ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 8'($urandom), $urandom, 5'd8, 5'd8, 5'd1);
      step();
    end
    chk("hold_pc", {32'd0, ex_pc}, {32'd0, held_pc});
    ex_hold = 1'b0;

    // Five load-use bubbles: narrow counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      set_id(1'b1, 8'h2D, 32'h300 + 32'(i * 8), 5'd1, 5'd2, 5'd10);
      step();
      set_id(1'b1, 8'h88, 32'h304 + 32'(i * 8), 5'd11, 5'd10, 5'd12);
      step();
    end
    chk("sat_w2", {62'd0, bubble_count2}, 64'd3);
    chk("count_w16", {48'd0, bubble_count}, 64'd6);

    // Reset in the middle of a hold.
    ex_hold = 1'b1;
    step();
    rst = 1'b1;
    step();
    chk("rst_hold_valid", {63'd0, ex_valid}, 64'd0);
    chk("rst_hold_count", {48'd0, bubble_count}, 64'd0);
    rst = 1'b0; ex_hold = 1'b0;

    // Random traffic with small register numbers to provoke hazards.
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] c;
      c = 8'($urandom);
      c[5] = ($urandom_range(0, 1) == 1);
      set_id(($urandom_range(0, 9) != 0), c, $urandom,
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      rst     = ($urandom_range(0, 99) < 2);
      flush   = ($urandom_range(0, 99) < 8);
      ex_hold = ($urandom_range(0, 99) < 15);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
